// File: rtl/rv_mc_pkg.sv
// rv_mc_pkg
// Shared definitions for the multicycle RISC-V control unit and datapath.
// Contents: FSM state codes, mux-select encodings for the datapath, internal
// ALUOp encodings, supported opcodes, and a helper that recognises them.
package rv_mc_pkg;

  // Debug-visible state codes; 11..15 are unused and recover to FETCH
  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10
  } statetype_e;

  // ALU operand A select
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  // ALU operand B select
  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // Result bus select
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // Memory address select
  localparam logic ADR_PC     = 1'b0;
  localparam logic ADR_RESULT = 1'b1;

  // Internal ALUOp handed to the ALU decoder
  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_SUB    = 2'b01;
  localparam logic [1:0] ALUOP_DECODE = 2'b10;

  // Immediate format select
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // Supported opcodes
  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  // True when the controller knows how to sequence this opcode
  function automatic logic isLegalOp(input logic [6:0] opcode);
    return (opcode == OP_LW) || (opcode == OP_SW) || (opcode == OP_RTYPE) ||
           (opcode == OP_ITYPE) || (opcode == OP_BEQ) || (opcode == OP_JAL);
  endfunction

endpackage

// File: rtl/aludec.sv
// aludec
// Maps the controller's ALUOp plus instruction fields onto an ALU operation.
// Ports:
//   opb5       - bit 5 of the opcode (separates R-type from I-type)
//   funct3     - instruction funct3 field
//   funct7b5   - bit 5 of funct7 (sub vs add for R-type)
//   ALUOp      - 00 add, 01 sub, 10 decode from funct fields
//   ALUControl - ALU operation code
module aludec
  import rv_mc_pkg::*;
(
  input  logic       opb5,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic [1:0] ALUOp,
  output logic [2:0] ALUControl
);

  logic rtypeSub;

  // Only R-type uses funct7b5 to pick sub; addi with a set bit 30 is still add
  assign rtypeSub = funct7b5 & opb5;

  // Forced add/sub for address and branch work, otherwise decode funct3.
  // Unknown funct3 values fall back to add so the ALU never sees X.
  always_comb begin
    ALUControl = 3'b000;
    case (ALUOp)
      ALUOP_ADD: ALUControl = 3'b000;
      ALUOP_SUB: ALUControl = 3'b001;
      default: begin
        case (funct3)
          3'b000:  ALUControl = rtypeSub ? 3'b001 : 3'b000;
          3'b010:  ALUControl = 3'b101;
          3'b110:  ALUControl = 3'b011;
          3'b111:  ALUControl = 3'b010;
          default: ALUControl = 3'b000;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl
// Moore control FSM for the multicycle RISC-V core with a unified memory.
// Parameter MEM_WAIT (0..7) adds wait cycles to FETCH and MEMREAD.
// Ports:
//   clk, reset                 - clock and asynchronous active-high reset
//   op, funct3, funct7b5       - fields from the instruction register
//   Zero                       - ALU zero flag, used by beq
//   PCWrite, AdrSrc, IRWrite,
//   MemWrite, RegWrite         - datapath write enables / address select
//   ResultSrc, ALUSrcA,
//   ALUSrcB, ImmSrc            - datapath mux selects
//   ALUControl                 - ALU operation
//   illegal                    - one-cycle pulse in DECODE of an unsupported op
//   state                      - current state, debug only
module multicycle_ctrl
  import rv_mc_pkg::*;
#(
  parameter int unsigned MEM_WAIT = 0
)(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       illegal,
  output logic [3:0] state
);

  localparam logic [2:0] WAIT_LAST = 3'(MEM_WAIT);

  statetype_e state_q, state_d;
  logic [2:0] waitCnt_q, waitCnt_d;
  logic       lastWait;
  logic       pcWriteRaw, irWriteRaw, memWriteRaw, regWriteRaw;
  logic [1:0] aluOp;

  // Final cycle of a memory access: the counter has reached the wait budget
  assign lastWait = (waitCnt_q == WAIT_LAST);

  // State and wait counter; reset drops straight back to FETCH with a fresh count
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= FETCH;
      waitCnt_q <= 3'd0;
    end else begin
      state_q   <= state_d;
      waitCnt_q <= waitCnt_d;
    end
  end

  // Next-state logic. The counter only runs while FETCH or MEMREAD is being
  // held; any transition zeroes it, so both states always start from zero.
  always_comb begin
    state_d   = FETCH;
    waitCnt_d = 3'd0;
    case (state_q)
      FETCH: begin
        if (lastWait) begin
          state_d = DECODE;
        end else begin
          state_d   = FETCH;
          waitCnt_d = waitCnt_q + 3'd1;
        end
      end
      DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = EXECUTER;
          OP_ITYPE:     state_d = EXECUTEI;
          OP_BEQ:       state_d = BEQ;
          OP_JAL:       state_d = JAL;
          default:      state_d = FETCH;
        endcase
      end
      MEMADR: state_d = (op == OP_SW) ? MEMWRITE : MEMREAD;
      MEMREAD: begin
        if (lastWait) begin
          state_d = MEMWB;
        end else begin
          state_d   = MEMREAD;
          waitCnt_d = waitCnt_q + 3'd1;
        end
      end
      EXECUTER, EXECUTEI, JAL: state_d = ALUWB;
      default: state_d = FETCH;
    endcase
  end

  // Per-state datapath controls. Everything defaults to zero/PC/add so only
  // the deviations are listed. BEQ's PCWrite follows Zero directly.
  always_comb begin
    pcWriteRaw  = 1'b0;
    irWriteRaw  = 1'b0;
    memWriteRaw = 1'b0;
    regWriteRaw = 1'b0;
    AdrSrc      = ADR_PC;
    ResultSrc   = RES_ALUOUT;
    ALUSrcA     = SRCA_PC;
    ALUSrcB     = SRCB_RS2;
    aluOp       = ALUOP_ADD;
    case (state_q)
      FETCH: begin
        ALUSrcB    = SRCB_FOUR;
        ResultSrc  = RES_ALURESULT;
        irWriteRaw = lastWait;
        pcWriteRaw = lastWait;
      end
      DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
      end
      MEMADR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
      end
      MEMREAD:  AdrSrc = ADR_RESULT;
      MEMWB: begin
        ResultSrc   = RES_DATA;
        regWriteRaw = 1'b1;
      end
      MEMWRITE: begin
        AdrSrc      = ADR_RESULT;
        memWriteRaw = 1'b1;
      end
      EXECUTER: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_RS2;
        aluOp   = ALUOP_DECODE;
      end
      EXECUTEI: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        aluOp   = ALUOP_DECODE;
      end
      ALUWB:    regWriteRaw = 1'b1;
      BEQ: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_RS2;
        aluOp      = ALUOP_SUB;
        pcWriteRaw = Zero;
      end
      JAL: begin
        ALUSrcA    = SRCA_OLDPC;
        ALUSrcB    = SRCB_FOUR;
        pcWriteRaw = 1'b1;
      end
      default: ;
    endcase
  end

  // Immediate format depends only on the opcode, not on the state
  always_comb begin
    case (op)
      OP_SW:   ImmSrc = IMM_S;
      OP_BEQ:  ImmSrc = IMM_B;
      OP_JAL:  ImmSrc = IMM_J;
      default: ImmSrc = IMM_I;
    endcase
  end

  // Write enables are masked during reset: the reset state is FETCH, which
  // would otherwise raise IRWrite/PCWrite when MEM_WAIT is zero.
  assign PCWrite  = pcWriteRaw  & ~reset;
  assign IRWrite  = irWriteRaw  & ~reset;
  assign MemWrite = memWriteRaw & ~reset;
  assign RegWrite = regWriteRaw & ~reset;
  assign illegal  = (state_q == DECODE) & ~isLegalOp(op) & ~reset;
  assign state    = state_q;

  aludec u_aludec (
    .opb5      (op[5]),
    .funct3    (funct3),
    .funct7b5  (funct7b5),
    .ALUOp     (aluOp),
    .ALUControl(ALUControl)
  );

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl
// Self-checking bench for multicycle_ctrl. Three instances with MEM_WAIT of
// 0, 2 and 3 share the instruction inputs; each has its own reset so only
// the instance under test runs while the others are held in reset.
module tb_multicycle_ctrl;

  localparam logic [6:0] LW   = 7'b0000011;
  localparam logic [6:0] SW   = 7'b0100011;
  localparam logic [6:0] RT   = 7'b0110011;
  localparam logic [6:0] IT   = 7'b0010011;
  localparam logic [6:0] BQ   = 7'b1100011;
  localparam logic [6:0] JL   = 7'b1101111;
  localparam logic [6:0] BAD0 = 7'b0000000;
  localparam logic [6:0] BAD1 = 7'b0010111;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, rst2, rst3;
  logic [6:0] op;
  logic [2:0] funct3;
  logic funct7b5, Zero;

  logic pcw0, adr0, irw0, mw0, rw0, ill0;
  logic [1:0] rs0, sa0, sb0, imm0;
  logic [2:0] alc0;
  logic [3:0] st0;
  logic pcw2, adr2, irw2, mw2, rw2, ill2;
  logic [1:0] rs2, sa2, sb2, imm2;
  logic [2:0] alc2;
  logic [3:0] st2;
  logic pcw3, adr3, irw3, mw3, rw3, ill3;
  logic [1:0] rs3, sa3, sb3, imm3;
  logic [2:0] alc3;
  logic [3:0] st3;

  multicycle_ctrl #(.MEM_WAIT(0)) u0 (
    .clk(clk), .reset(rst0), .op(op), .funct3(funct3), .funct7b5(funct7b5), .Zero(Zero),
    .PCWrite(pcw0), .AdrSrc(adr0), .IRWrite(irw0), .MemWrite(mw0), .RegWrite(rw0),
    .ResultSrc(rs0), .ALUSrcA(sa0), .ALUSrcB(sb0), .ImmSrc(imm0), .ALUControl(alc0),
    .illegal(ill0), .state(st0));

  multicycle_ctrl #(.MEM_WAIT(2)) u2 (
    .clk(clk), .reset(rst2), .op(op), .funct3(funct3), .funct7b5(funct7b5), .Zero(Zero),
    .PCWrite(pcw2), .AdrSrc(adr2), .IRWrite(irw2), .MemWrite(mw2), .RegWrite(rw2),
    .ResultSrc(rs2), .ALUSrcA(sa2), .ALUSrcB(sb2), .ImmSrc(imm2), .ALUControl(alc2),
    .illegal(ill2), .state(st2));

  multicycle_ctrl #(.MEM_WAIT(3)) u3 (
    .clk(clk), .reset(rst3), .op(op), .funct3(funct3), .funct7b5(funct7b5), .Zero(Zero),
    .PCWrite(pcw3), .AdrSrc(adr3), .IRWrite(irw3), .MemWrite(mw3), .RegWrite(rw3),
    .ResultSrc(rs3), .ALUSrcA(sa3), .ALUSrcB(sb3), .ImmSrc(imm3), .ALUControl(alc3),
    .illegal(ill3), .state(st3));

  // One row per clock cycle of the MEM_WAIT=0 instance
  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    logic       z;
    logic [3:0] st;
    logic       pcw, irw, mw, rw, adr;
    logic [1:0] rs, sa, sb, imm;
    logic [2:0] alc;
    logic       ill;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int fails  = 0;

  int expSt2 [16] = '{0, 0, 0, 1, 2, 5, 0, 0, 0, 1, 2, 3, 3, 3, 4, 0};
  int expSt3a [9] = '{0, 0, 0, 0, 1, 2, 3, 3, 3};
  int expSt3b [8] = '{0, 0, 0, 0, 1, 0, 0, 0};

  function automatic vec_t mk(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                              input logic z, input logic [3:0] st, input logic pcw,
                              input logic irw, input logic mw, input logic rw, input logic adr,
                              input logic [1:0] rs, input logic [1:0] sa, input logic [1:0] sb,
                              input logic [1:0] imm, input logic [2:0] alc, input logic ill);
    vec_t v;
    v.op = o; v.f3 = f3; v.f7 = f7; v.z = z; v.st = st;
    v.pcw = pcw; v.irw = irw; v.mw = mw; v.rw = rw; v.adr = adr;
    v.rs = rs; v.sa = sa; v.sb = sb; v.imm = imm; v.alc = alc; v.ill = ill;
    return v;
  endfunction

  // FETCH and DECODE rows shared by every legal instruction at MEM_WAIT=0
  task automatic addFD(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                       input logic z, input logic [1:0] imm);
    vecs.push_back(mk(o, f3, f7, z, 4'd0, 1, 1, 0, 0, 0, 2'b10, 2'b00, 2'b10, imm, 3'b000, 0));
    vecs.push_back(mk(o, f3, f7, z, 4'd1, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, imm, 3'b000, 0));
  endtask

  task automatic buildVectors();
    // lw
    addFD(LW, 3'b010, 0, 0, 2'b00);
    vecs.push_back(mk(LW, 3'b010, 0, 0, 4'd2, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000, 0));
    vecs.push_back(mk(LW, 3'b010, 0, 0, 4'd3, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0));
    vecs.push_back(mk(LW, 3'b010, 0, 0, 4'd4, 0, 0, 0, 1, 0, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000, 0));
    // sw
    addFD(SW, 3'b010, 0, 0, 2'b01);
    vecs.push_back(mk(SW, 3'b010, 0, 0, 4'd2, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b01, 3'b000, 0));
    vecs.push_back(mk(SW, 3'b010, 0, 0, 4'd5, 0, 0, 1, 0, 1, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000, 0));
    // R-type sub, add, slt, and, sll (unsupported funct3 -> add)
    addFD(RT, 3'b000, 1, 0, 2'b00);
    vecs.push_back(mk(RT, 3'b000, 1, 0, 4'd6, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b00, 3'b001, 0));
    vecs.push_back(mk(RT, 3'b000, 1, 0, 4'd8, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0));
    addFD(RT, 3'b000, 0, 0, 2'b00);
    vecs.push_back(mk(RT, 3'b000, 0, 0, 4'd6, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b00, 3'b000, 0));
    vecs.push_back(mk(RT, 3'b000, 0, 0, 4'd8, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0));
    addFD(RT, 3'b010, 0, 0, 2'b00);
    vecs.push_back(mk(RT, 3'b010, 0, 0, 4'd6, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b00, 3'b101, 0));
    vecs.push_back(mk(RT, 3'b010, 0, 0, 4'd8, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0));
    addFD(RT, 3'b111, 0, 0, 2'b00);
    vecs.push_back(mk(RT, 3'b111, 0, 0, 4'd6, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b00, 3'b010, 0));
    vecs.push_back(mk(RT, 3'b111, 0, 0, 4'd8, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0));
    addFD(RT, 3'b001, 1, 0, 2'b00);
    vecs.push_back(mk(RT, 3'b001, 1, 0, 4'd6, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b00, 3'b000, 0));
    vecs.push_back(mk(RT, 3'b001, 1, 0, 4'd8, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0));
    // I-type ori, and addi with bit 30 set (must stay add)
    addFD(IT, 3'b110, 0, 0, 2'b00);
    vecs.push_back(mk(IT, 3'b110, 0, 0, 4'd7, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b011, 0));
    vecs.push_back(mk(IT, 3'b110, 0, 0, 4'd8, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0));
    addFD(IT, 3'b000, 1, 0, 2'b00);
    vecs.push_back(mk(IT, 3'b000, 1, 0, 4'd7, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000, 0));
    vecs.push_back(mk(IT, 3'b000, 1, 0, 4'd8, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0));
    // beq taken and not taken
    addFD(BQ, 3'b000, 0, 1, 2'b10);
    vecs.push_back(mk(BQ, 3'b000, 0, 1, 4'd9, 1, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 3'b001, 0));
    addFD(BQ, 3'b000, 0, 0, 2'b10);
    vecs.push_back(mk(BQ, 3'b000, 0, 0, 4'd9, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 3'b001, 0));
    // jal
    addFD(JL, 3'b000, 0, 0, 2'b11);
    vecs.push_back(mk(JL, 3'b000, 0, 0, 4'd10, 1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b11, 3'b000, 0));
    vecs.push_back(mk(JL, 3'b000, 0, 0, 4'd8, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b11, 3'b000, 0));
    // unsupported opcodes: DECODE flags illegal and returns to FETCH
    vecs.push_back(mk(BAD0, 3'b000, 0, 0, 4'd0, 1, 1, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 0));
    vecs.push_back(mk(BAD0, 3'b000, 0, 0, 4'd1, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000, 1));
    vecs.push_back(mk(BAD1, 3'b000, 0, 0, 4'd0, 1, 1, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 0));
    vecs.push_back(mk(BAD1, 3'b000, 0, 0, 4'd1, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000, 1));
    vecs.push_back(mk(LW, 3'b010, 0, 0, 4'd0, 1, 1, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 0));
  endtask

  task automatic applyStimulus(input logic [6:0] o, input logic [2:0] f3,
                               input logic f7, input logic z);
    op       = o;
    funct3   = f3;
    funct7b5 = f7;
    Zero     = z;
  endtask

  task automatic checkOutput(input string name, input int idx,
                             input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  initial begin
    rst0 = 1'b1;
    rst2 = 1'b1;
    rst3 = 1'b1;
    applyStimulus(LW, 3'b010, 1'b0, 1'b0);

    // Reset state: FETCH with every write enable held low, even across an edge
    #1;
    checkOutput("rst_state", 0, 32'(st0), 32'd0);
    checkOutput("rst_irw", 0, 32'(irw0), 32'd0);
    checkOutput("rst_pcw", 0, 32'(pcw0), 32'd0);
    checkOutput("rst_rw", 0, 32'(rw0), 32'd0);
    @(negedge clk);
    #1;
    checkOutput("rst_state", 1, 32'(st0), 32'd0);
    checkOutput("rst_irw", 1, 32'(irw0), 32'd0);

    // Table-driven run on the MEM_WAIT=0 instance
    buildVectors();
    @(negedge clk);
    rst0 = 1'b0;
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].z);
      #1;
      checkOutput("state", i, 32'(st0), 32'(vecs[i].st));
      checkOutput("PCWrite", i, 32'(pcw0), 32'(vecs[i].pcw));
      checkOutput("IRWrite", i, 32'(irw0), 32'(vecs[i].irw));
      checkOutput("MemWrite", i, 32'(mw0), 32'(vecs[i].mw));
      checkOutput("RegWrite", i, 32'(rw0), 32'(vecs[i].rw));
      checkOutput("AdrSrc", i, 32'(adr0), 32'(vecs[i].adr));
      checkOutput("ResultSrc", i, 32'(rs0), 32'(vecs[i].rs));
      checkOutput("ALUSrcA", i, 32'(sa0), 32'(vecs[i].sa));
      checkOutput("ALUSrcB", i, 32'(sb0), 32'(vecs[i].sb));
      checkOutput("ImmSrc", i, 32'(imm0), 32'(vecs[i].imm));
      checkOutput("ALUControl", i, 32'(alc0), 32'(vecs[i].alc));
      checkOutput("illegal", i, 32'(ill0), 32'(vecs[i].ill));
      @(negedge clk);
    end

    // MEM_WAIT=2: sw then lw; FETCH and MEMREAD each last three cycles
    rst0 = 1'b1;
    rst2 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i < 6) applyStimulus(SW, 3'b010, 1'b0, 1'b0);
      else       applyStimulus(LW, 3'b010, 1'b0, 1'b0);
      #1;
      checkOutput("w2_state", i, 32'(st2), 32'(expSt2[i]));
      checkOutput("w2_IRWrite", i, 32'(irw2), 32'((i == 2) || (i == 8)));
      checkOutput("w2_PCWrite", i, 32'(pcw2), 32'((i == 2) || (i == 8)));
      checkOutput("w2_MemWrite", i, 32'(mw2), 32'(i == 5));
      checkOutput("w2_RegWrite", i, 32'(rw2), 32'(i == 14));
      checkOutput("w2_AdrSrc", i, 32'(adr2), 32'((i == 5) || (i >= 11 && i <= 13)));
      @(negedge clk);
    end

    // MEM_WAIT=3: lw aborted by reset in the middle of MEMREAD
    rst2 = 1'b1;
    rst3 = 1'b0;
    applyStimulus(LW, 3'b010, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) begin
      #1;
      checkOutput("w3_state", i, 32'(st3), 32'(expSt3a[i]));
      checkOutput("w3_IRWrite", i, 32'(irw3), 32'(i == 3));
      checkOutput("w3_RegWrite", i, 32'(rw3), 32'd0);
      if (i < 8) @(negedge clk);
    end
    #1;
    rst3 = 1'b1;
    #1;
    checkOutput("w3_async_state", 0, 32'(st3), 32'd0);
    checkOutput("w3_async_RegWrite", 0, 32'(rw3), 32'd0);
    checkOutput("w3_async_IRWrite", 0, 32'(irw3), 32'd0);
    @(negedge clk);
    #1;
    checkOutput("w3_async_state", 1, 32'(st3), 32'd0);
    checkOutput("w3_async_RegWrite", 1, 32'(rw3), 32'd0);
    applyStimulus(BAD0, 3'b000, 1'b0, 1'b0);
    @(negedge clk);
    rst3 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      checkOutput("w3_restart_state", i, 32'(st3), 32'(expSt3b[i]));
      checkOutput("w3_restart_IRWrite", i, 32'(irw3), 32'(i == 3));
      checkOutput("w3_restart_illegal", i, 32'(ill3), 32'(i == 4));
      checkOutput("w3_restart_RegWrite", i, 32'(rw3), 32'd0);
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter MEM_WAIT, default 0, range 0..7: extra wait cycles the unified memory needs in FETCH and MEMREAD.
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port op  input  7  opcode from the instruction register.
REQ-005 SHALL have ports funct3 (input, 3) and funct7b5 (input, 1), both from the instruction register.
REQ-006 SHALL have port Zero  input  1  ALU zero flag.
REQ-007 SHALL have ports PCWrite, AdrSrc, IRWrite, MemWrite and RegWrite, each output, 1 bit.
REQ-008 SHALL have ports ResultSrc, ALUSrcA, ALUSrcB and ImmSrc, each output, 2 bits.
REQ-009 SHALL have port ALUControl  output  3  ALU operation.
REQ-010 SHALL have port illegal  output  1  pulse flagging an unsupported opcode.
REQ-011 SHALL have port state  output  4  current state, for debug only.

Function
REQ-012 SHALL be a Moore FSM with state codes FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BEQ=9, JAL=10; codes 11..15 SHALL go to FETCH on the next edge.
REQ-013 Transitions SHALL be: FETCH->DECODE.
REQ-014 DECODE SHALL branch on op: lw 0000011 or sw 0100011 -> MEMADR; R 0110011 -> EXECUTER; I 0010011 -> EXECUTEI; beq 1100011 -> BEQ; jal 1101111 -> JAL; any other op -> FETCH.
REQ-015 MEMADR SHALL go to MEMREAD for lw and to MEMWRITE for sw.
REQ-016 Remaining transitions SHALL be: MEMREAD->MEMWB; EXECUTER/EXECUTEI/JAL->ALUWB; MEMWB/MEMWRITE/ALUWB/BEQ->FETCH.
REQ-017 A 3-bit wait counter SHALL hold FETCH and MEMREAD for MEM_WAIT+1 cycles; it SHALL clear on entering either state, and every other state SHALL last exactly 1 cycle.
REQ-018 Select encodings: ALUSrcA 00=PC, 01=OldPC, 10=rs1. ALUSrcB 00=rs2, 01=ImmExt, 10=constant 4. ResultSrc 00=ALUOut, 01=Data, 10=ALUResult. AdrSrc 0=PC, 1=Result.
REQ-019 FETCH SHALL drive AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ResultSrc=10 and ALUOp=add; IRWrite and PCWrite SHALL be 1 only in the final wait cycle.
REQ-020 DECODE SHALL drive ALUSrcA=01, ALUSrcB=01, add. MEMADR SHALL drive ALUSrcA=10, ALUSrcB=01, add.
REQ-021 MEMREAD SHALL drive AdrSrc=1, ResultSrc=00. MEMWB SHALL drive ResultSrc=01, RegWrite=1. MEMWRITE SHALL drive AdrSrc=1, ResultSrc=00, MemWrite=1.
REQ-022 EXECUTER SHALL drive ALUSrcA=10, ALUSrcB=00, decoded op. EXECUTEI SHALL drive ALUSrcA=10, ALUSrcB=01, decoded op. ALUWB SHALL drive ResultSrc=00, RegWrite=1.
REQ-023 BEQ SHALL drive ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00, with PCWrite=Zero.
REQ-024 JAL SHALL drive ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1.
REQ-025 Unlisted outputs SHALL be 0 in every state.
REQ-026 ImmSrc SHALL be combinational from op: sw 01, beq 10, jal 11, all others 00.
REQ-027 ALUControl SHALL be: add 000; sub 001.
REQ-028 For the decoded op, ALUControl SHALL follow funct3: 000 gives sub if funct7b5&op[5], else add; 010 gives 101; 110 gives 011; 111 gives 010; any other funct3 gives 000, never X.
REQ-029 illegal SHALL be 1 for exactly the DECODE cycle of an unsupported op, and no write enable SHALL assert for that instruction.

Reset
REQ-030 While reset=1, state SHALL be FETCH immediately (asynchronously), the wait counter SHALL be 0, and PCWrite, IRWrite, MemWrite, RegWrite and illegal SHALL be forced 0.
REQ-031 Reset mid-instruction SHALL abandon that instruction, and the first fetch SHALL begin on the first edge after reset deasserts.

Structure
REQ-032 State codes and mux-select encodings SHALL live in shared package rv_mc_pkg, which the multicycle datapath also uses.
REQ-033 ALU decoding SHALL be the existing aludec sub-module, instantiated unchanged and fed an internal 2-bit ALUOp; no other sub-modules.

Verification
REQ-034 MEM_WAIT=0, lw (op 0000011) -> states 0,1,2,3,4,0; RegWrite=1 only in state 4; ResultSrc=01 there.
REQ-035 beq with Zero=1 -> state 9 has PCWrite=1, ALUControl=001; repeated with Zero=0 -> PCWrite=0; each takes 3 cycles.
REQ-036 R-type sub (funct3 000, funct7b5 1) -> state 6 has ALUControl=001; state 8 has RegWrite=1; 4 cycles total.
REQ-037 MEM_WAIT=2, sw -> FETCH lasts 3 cycles with IRWrite=1 only in the 3rd; MEMWRITE lasts 1 cycle with MemWrite=1 and AdrSrc=1.
REQ-038 op 0000000 -> states 0,1,0; illegal=1 for one cycle; no write enable in state 1.
REQ-039 reset asserted mid-MEMREAD, MEM_WAIT=3 -> state=0 before the next edge; RegWrite is never asserted for the aborted lw.
